// File: rtl/aluv_result_drain.sv
// Snapshots ALUs_num result lanes, streams them lane 0 first; optional ALUV_DRAIN_PARITY_EN adds m_parity.
// Latency 1 cycle capture-to-first-beat; beats hold while m_ready=0, next snapshot loads on last-beat cycle.
module aluv_result_drain #(
    parameter  int ALUs_num    = 4,
    parameter  int INPUT_WIDTH = 8,
    localparam int LIDX_W      = (ALUs_num > 1) ? $clog2(ALUs_num) : 1,
    localparam int DW          = 2 * INPUT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     result [ALUs_num],
    input  logic              cap_valid,
    output logic              cap_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [LIDX_W-1:0] m_lane,
    output logic              m_last,
`ifdef ALUV_DRAIN_PARITY_EN
    output logic              m_parity,
`endif
    output logic              busy
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(ALUs_num - 1);

    state_t            state, state_nxt;
    logic [LIDX_W-1:0] cnt, cnt_nxt;
    logic [DW-1:0]     snap [ALUs_num];
    logic              cap_fire;
`ifdef ALUV_DRAIN_PARITY_EN
    logic              par_q [ALUs_num];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            for (int i = 0; i < ALUs_num; i++) begin
                snap[i] <= '0;
`ifdef ALUV_DRAIN_PARITY_EN
                par_q[i] <= 1'b0;
`endif
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (cap_fire) begin
                for (int i = 0; i < ALUs_num; i++) begin
                    snap[i] <= result[i];
`ifdef ALUV_DRAIN_PARITY_EN
                    par_q[i] <= ^result[i];
`endif
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_ready = 1'b0;
        cap_fire  = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_lane    = '0;
        m_last    = 1'b0;
        busy      = 1'b0;
`ifdef ALUV_DRAIN_PARITY_EN
        m_parity  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cap_ready = 1'b1;
                if (cap_valid) begin
                    cap_fire  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                busy    = 1'b1;
                m_data  = snap[cnt];
                m_lane  = cnt;
                m_last  = (cnt == LAST_IDX);
`ifdef ALUV_DRAIN_PARITY_EN
                m_parity = par_q[cnt];
`endif
                if (m_ready) begin
                    if (cnt == LAST_IDX) begin
                        // Last beat leaving: a waiting snapshot reloads with no bubble
                        cap_ready = 1'b1;
                        cnt_nxt   = '0;
                        if (cap_valid) cap_fire = 1'b1;
                        else           state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + LIDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
